// File: rtl/kuznechik_apb_block_driver.sv
// kuznechik_apb_block_driver
//   APB master that moves one 128-bit block at a time through the Kuznechik
//   cipher APB slave. For each accepted block it writes DATA_IN0..3, pulses
//   REQ, polls VALID, reads DATA_OUT0..3, writes ACK, and then presents the
//   result on the output stream. Only one block is in flight at a time.
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   in_valid_i/in_ready_o/in_data_i     plaintext stream (word0 = [31:0])
//   out_valid_o/out_ready_i/out_data_o  result stream (word0 = [31:0])
//   out_err_o                    result invalid (slverr or poll timeout)
//   busy_o                       driver not idle
//   apb_*                        APB master towards the cipher slave
module kuznechik_apb_block_driver #(
  parameter int unsigned                APB_ADDR_WIDTH = 12,
  parameter int unsigned                APB_DATA_WIDTH = 32,
  parameter logic [APB_ADDR_WIDTH-1:0]  BASE_ADDR      = '0,
  parameter int unsigned                POLL_LIMIT     = 1024
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [127:0]              in_data_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [127:0]              out_data_o,
  output logic                      out_err_o,
  output logic                      busy_o,
  output logic [APB_ADDR_WIDTH-1:0] apb_paddr_o,
  output logic [APB_DATA_WIDTH-1:0] apb_pwdata_o,
  output logic                      apb_pwrite_o,
  output logic                      apb_psel_o,
  output logic                      apb_penable_o,
  input  logic [APB_DATA_WIDTH-1:0] apb_prdata_i,
  input  logic                      apb_pready_i,
  input  logic                      apb_pslverr_i
);

  localparam int unsigned CW = $clog2(POLL_LIMIT + 1);

  if (APB_DATA_WIDTH != 32) begin : g_bad_width
    $error("kuznechik_apb_block_driver: APB_DATA_WIDTH must be 32");
  end

  typedef enum logic [3:0] {
    S_INIT_CLR, S_INIT_SET, S_IDLE, S_WR_DIN, S_WR_REQ,
    S_POLL, S_RD_DOUT, S_WR_ACK, S_OUT
  } state_t;

  state_t                    state_q, state_d;
  logic [1:0]                idx_q, idx_d;
  logic [CW-1:0]             poll_q, poll_d;
  logic [127:0]              din_q, din_d;
  logic [127:0]              out_data_q, out_data_d;
  logic                      out_valid_q, out_valid_d;
  logic                      out_err_q, out_err_d;
  logic                      psel_q, psel_d;
  logic                      penable_q, penable_d;
  logic                      pwrite_q, pwrite_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [31:0]               pwdata_q, pwdata_d;
  logic                      start;
  logic                      fail;
  logic [7:0]                off;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    poll_d      = poll_q;
    din_d       = din_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_err_d   = out_err_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    start       = 1'b0;
    fail        = 1'b0;
    off         = '0;

    case (state_q)
      S_IDLE: begin
        if (in_valid_i) begin
          din_d   = in_data_i;
          idx_d   = '0;
          state_d = S_WR_DIN;
          start   = 1'b1;
        end
      end
      S_OUT: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          state_d     = out_err_q ? S_INIT_CLR : S_IDLE;
          start       = out_err_q;
        end
      end
      default: begin
        // Bus registers are cleared by reset, so the first INIT transfer
        // needs one cycle to issue its SETUP phase.
        if (!psel_q) begin
          start = 1'b1;
        end else if (!penable_q) begin
          penable_d = 1'b1;
        end else if (apb_pready_i) begin
          // Completion: the next transfer's SETUP is issued on the same
          // edge unless the next state does not talk to the bus.
          start = 1'b1;
          case (state_q)
            S_INIT_CLR: state_d = S_INIT_SET;
            S_INIT_SET: begin
              state_d = S_IDLE;
              start   = 1'b0;
            end
            S_WR_DIN: begin
              if (apb_pslverr_i)    fail    = 1'b1;
              else if (idx_q == 2'd3) state_d = S_WR_REQ;
              else                  idx_d   = idx_q + 1'b1;
            end
            S_WR_REQ: begin
              if (apb_pslverr_i) begin
                fail = 1'b1;
              end else begin
                state_d = S_POLL;
                poll_d  = '0;
              end
            end
            S_POLL: begin
              if (apb_pslverr_i) begin
                fail = 1'b1;
              end else if (apb_prdata_i[0]) begin
                state_d = S_RD_DOUT;
                idx_d   = '0;
              end else if (poll_q == CW'(POLL_LIMIT - 1)) begin
                fail = 1'b1;
              end else begin
                poll_d = poll_q + 1'b1;
              end
            end
            S_RD_DOUT: begin
              if (apb_pslverr_i) begin
                fail = 1'b1;
              end else begin
                out_data_d[idx_q*32 +: 32] = apb_prdata_i[31:0];
                if (idx_q == 2'd3) state_d = S_WR_ACK;
                else               idx_d   = idx_q + 1'b1;
              end
            end
            S_WR_ACK: begin
              if (apb_pslverr_i) begin
                fail = 1'b1;
              end else begin
                state_d     = S_OUT;
                out_valid_d = 1'b1;
                out_err_d   = 1'b0;
                start       = 1'b0;
              end
            end
            default: ;
          endcase
          if (fail) begin
            state_d     = S_OUT;
            out_valid_d = 1'b1;
            out_err_d   = 1'b1;
            out_data_d  = '0;
            start       = 1'b0;
          end
        end
      end
    endcase

    if (start) begin
      psel_d    = 1'b1;
      penable_d = 1'b0;
      pwrite_d  = 1'b1;
      pwdata_d  = 32'h1;
      case (state_d)
        S_INIT_CLR: pwdata_d = '0;
        S_INIT_SET: off = 8'h00;
        S_WR_DIN: begin
          off      = 8'h14 + {4'd0, idx_d, 2'b00};
          pwdata_d = din_d[idx_d*32 +: 32];
        end
        S_WR_REQ: off = 8'h04;
        S_POLL: begin
          off      = 8'h0C;
          pwrite_d = 1'b0;
          pwdata_d = '0;
        end
        S_RD_DOUT: begin
          off      = 8'h24 + {4'd0, idx_d, 2'b00};
          pwrite_d = 1'b0;
          pwdata_d = '0;
        end
        S_WR_ACK: off = 8'h08;
        default: begin
          psel_d   = 1'b0;
          pwrite_d = 1'b0;
          pwdata_d = '0;
        end
      endcase
      paddr_d = BASE_ADDR + APB_ADDR_WIDTH'(off);
    end else if (state_d == S_IDLE || state_d == S_OUT) begin
      psel_d    = 1'b0;
      penable_d = 1'b0;
      pwrite_d  = 1'b0;
      paddr_d   = '0;
      pwdata_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_INIT_CLR;
      idx_q       <= '0;
      poll_q      <= '0;
      din_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      poll_q      <= poll_d;
      din_q       <= din_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_err_q   <= out_err_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
    end
  end

  assign in_ready_o    = (state_q == S_IDLE);
  assign busy_o        = (state_q != S_IDLE);
  assign out_valid_o   = out_valid_q;
  assign out_data_o    = out_data_q;
  assign out_err_o     = out_err_q;
  assign apb_psel_o    = psel_q;
  assign apb_penable_o = penable_q;
  assign apb_pwrite_o  = pwrite_q;
  assign apb_paddr_o   = paddr_q;
  assign apb_pwdata_o  = pwdata_q;

endmodule

// File: tb/tb_kuznechik_apb_block_driver.sv
module tb_kuznechik_apb_block_driver;

  localparam int unsigned PL = 4;

  typedef struct packed {
    logic [11:0] addr;
    logic        wr;
    logic [31:0] data;
  } xfer_t;

  typedef struct {
    logic [127:0] pt;
    logic [127:0] dout;
    int unsigned  valid_after;  // 0: VALID never set
    int unsigned  waits;
    logic [11:0]  err_addr;     // 12'hFFF: no error injection
    logic         exp_err;
    logic [127:0] exp_data;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic         out_err;
  logic         busy;
  logic [11:0]  paddr;
  logic [31:0]  pwdata;
  logic         pwrite, psel, pen;
  logic [31:0]  prdata;
  logic         pready, pslverr;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  always #5 clk = ~clk;

  kuznechik_apb_block_driver #(
    .APB_ADDR_WIDTH(12),
    .APB_DATA_WIDTH(32),
    .BASE_ADDR(12'h000),
    .POLL_LIMIT(PL)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .out_err_o(out_err), .busy_o(busy),
    .apb_paddr_o(paddr), .apb_pwdata_o(pwdata), .apb_pwrite_o(pwrite),
    .apb_psel_o(psel), .apb_penable_o(pen), .apb_prdata_i(prdata),
    .apb_pready_i(pready), .apb_pslverr_i(pslverr)
  );

  function automatic void chk(input bit ok, input string name,
                              input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endfunction

  // ---------------- APB slave model ----------------
  int unsigned  cfg_waits = 0;
  int unsigned  cfg_valid_after = 1;
  logic [127:0] cfg_dout = '0;
  logic [11:0]  cfg_err_addr = 12'hFFF;
  int unsigned  wcnt = 0;
  int unsigned  vcount = 0;
  xfer_t        log_q[$];

  always_comb begin
    pready  = psel && pen && (wcnt >= cfg_waits);
    pslverr = pready && (paddr == cfg_err_addr);
    case (paddr)
      12'h00C: prdata = {31'd0, (cfg_valid_after != 0) && (vcount + 1 >= cfg_valid_after)};
      12'h024: prdata = cfg_dout[31:0];
      12'h028: prdata = cfg_dout[63:32];
      12'h02C: prdata = cfg_dout[95:64];
      12'h030: prdata = cfg_dout[127:96];
      default: prdata = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    if (rst) begin
      wcnt   <= 0;
      vcount <= 0;
    end else begin
      if (psel && pen && !pready) wcnt <= wcnt + 1;
      else                        wcnt <= 0;
      if (pready) begin
        log_q.push_back({paddr, pwrite, pwdata});
        if (pwrite && paddr == 12'h004)       vcount <= 0;
        else if (!pwrite && paddr == 12'h00C) vcount <= vcount + 1;
      end
    end
  end

  // ---------------- APB protocol watcher ----------------
  bit          p_ok = 1'b0;
  logic        p_psel, p_pen, p_rdy, p_wr;
  logic [11:0] p_addr;
  logic [31:0] p_wd;

  always @(negedge clk) begin
    if (!rst && p_ok) begin
      if (p_psel && !p_pen)
        chk(psel && pen && paddr == p_addr && pwrite == p_wr && pwdata == p_wd,
            "setup_to_access", {psel, pen, paddr}, {1'b1, 1'b1, p_addr});
      if (p_psel && p_pen && !p_rdy)
        chk(psel && pen && paddr == p_addr && pwrite == p_wr && pwdata == p_wd,
            "wait_hold", {psel, pen, paddr}, {1'b1, 1'b1, p_addr});
      if (psel && !pwrite)
        chk(pwdata == 32'h0, "read_pwdata", pwdata, 128'h0);
    end
    p_ok   = !rst;
    p_psel = psel;
    p_pen  = pen;
    p_rdy  = pready;
    p_wr   = pwrite;
    p_addr = paddr;
    p_wd   = pwdata;
  end

  // ---------------- reference model ----------------
  // Expected APB transfer list for one block: the full nominal sequence,
  // cut after the first transfer that hits the injected error address.
  xfer_t exp_q[$];

  task automatic build_exp(input vec_t v, output bit err);
    xfer_t full[$];
    bit tmo;
    int unsigned npoll;
    exp_q.delete();
    for (int i = 0; i < 4; i++) full.push_back({12'h014 + 12'(4*i), 1'b1, v.pt[32*i +: 32]});
    full.push_back({12'h004, 1'b1, 32'h1});
    tmo   = (v.valid_after == 0) || (v.valid_after > PL);
    npoll = tmo ? PL : v.valid_after;
    for (int unsigned i = 0; i < npoll; i++) full.push_back({12'h00C, 1'b0, 32'h0});
    if (!tmo) begin
      for (int i = 0; i < 4; i++) full.push_back({12'h024 + 12'(4*i), 1'b0, 32'h0});
      full.push_back({12'h008, 1'b1, 32'h1});
    end
    err = tmo;
    foreach (full[i]) begin
      exp_q.push_back(full[i]);
      if (full[i].addr == v.err_addr) begin
        err = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_ready();
    int unsigned t = 0;
    @(negedge clk);
    while (!in_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk(in_ready, "in_ready_timeout", in_ready, 1);
  endtask

  task automatic chk_init();
    chk(log_q.size() == 2, "init_count", log_q.size(), 2);
    if (log_q.size() >= 2) begin
      chk(log_q[0] == {12'h000, 1'b1, 32'h0}, "init_rst_clr", log_q[0], {12'h000, 1'b1, 32'h0});
      chk(log_q[1] == {12'h000, 1'b1, 32'h1}, "init_rst_set", log_q[1], {12'h000, 1'b1, 32'h1});
    end
    chk(psel == 1'b0 && in_ready && !busy, "idle_after_init", {psel, in_ready, busy}, 3'b010);
  endtask

  task automatic run_vec(input vec_t v, input int unsigned hold);
    bit merr;
    int unsigned lat;
    logic [127:0] held;
    build_exp(v, merr);
    cfg_waits       = v.waits;
    cfg_valid_after = v.valid_after;
    cfg_dout        = v.dout;
    cfg_err_addr    = v.err_addr;
    wait_ready();
    log_q.delete();
    in_valid = 1'b1;
    in_data  = v.pt;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = '0;
    lat = 0;
    while (!out_valid && lat < 2000) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk(out_valid, "out_valid_timeout", out_valid, 1);
    chk(lat == exp_q.size() * (2 + v.waits), "latency", lat, exp_q.size() * (2 + v.waits));
    chk(out_err == v.exp_err, "out_err", out_err, v.exp_err);
    chk(out_data == v.exp_data, "out_data", out_data, v.exp_data);
    chk(log_q.size() == exp_q.size(), "xfer_count", log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      chk(log_q[i] == exp_q[i], "xfer", log_q[i], exp_q[i]);
    held = out_data;
    for (int unsigned k = 0; k < hold; k++) begin
      @(negedge clk);
      chk(out_valid && out_data == held && !in_ready && !psel, "out_hold",
          {out_valid, in_ready, psel, out_data}, {3'b100, held});
    end
    @(negedge clk);
    log_q.delete();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk(!out_valid, "out_valid_drop", out_valid, 0);
    if (v.exp_err) begin
      wait_ready();
      chk_init();
    end
  endtask

  vec_t tbl[8];
  logic [11:0] err_pool[11] = '{12'h014, 12'h018, 12'h01C, 12'h020, 12'h004, 12'h00C,
                                12'h024, 12'h028, 12'h02C, 12'h030, 12'h008};

  initial begin
    logic [127:0] pt0, do0;
    vec_t v;
    bit e;
    pt0 = 128'h1122334455667700ffeeddccbbaa9988;
    do0 = 128'h7f679d90bebc24305a468d42b9d4edcd;
    tbl[0] = '{pt: pt0, dout: do0, valid_after: 3, waits: 0, err_addr: 12'hFFF, exp_err: 0, exp_data: do0};
    tbl[1] = '{pt: pt0, dout: do0, valid_after: 3, waits: 5, err_addr: 12'hFFF, exp_err: 0, exp_data: do0};
    tbl[2] = '{pt: pt0, dout: do0, valid_after: 3, waits: 0, err_addr: 12'h018, exp_err: 1, exp_data: '0};
    tbl[3] = '{pt: pt0, dout: do0, valid_after: 0, waits: 0, err_addr: 12'hFFF, exp_err: 1, exp_data: '0};
    tbl[4] = '{pt: ~pt0, dout: ~do0, valid_after: 4, waits: 1, err_addr: 12'hFFF, exp_err: 0, exp_data: ~do0};
    tbl[5] = '{pt: do0, dout: pt0, valid_after: 1, waits: 2, err_addr: 12'h008, exp_err: 1, exp_data: '0};
    tbl[6] = '{pt: pt0, dout: do0, valid_after: 2, waits: 0, err_addr: 12'h00C, exp_err: 1, exp_data: '0};
    tbl[7] = '{pt: pt0, dout: do0, valid_after: 5, waits: 1, err_addr: 12'hFFF, exp_err: 1, exp_data: '0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk(!psel && !pen && !pwrite && paddr == 0 && pwdata == 0, "reset_apb",
        {psel, pen, pwrite, paddr, pwdata}, '0);
    chk(!in_ready && busy, "reset_ready_busy", {in_ready, busy}, 2'b01);
    chk(!out_valid && !out_err && out_data == '0, "reset_out", {out_valid, out_err, out_data}, '0);
    @(negedge clk);
    rst = 1'b0;
    wait_ready();
    chk_init();

    foreach (tbl[i]) run_vec(tbl[i], (i == 1) ? 10 : 1);

    for (int n = 0; n < 10; n++) begin
      v.pt    = {$urandom, $urandom, $urandom, $urandom};
      v.dout  = {$urandom, $urandom, $urandom, $urandom};
      v.valid_after = $urandom_range(0, 5);
      v.waits = $urandom_range(0, 3);
      v.err_addr = ($urandom_range(0, 2) == 0) ? err_pool[$urandom_range(0, 10)] : 12'hFFF;
      build_exp(v, e);
      v.exp_err  = e;
      v.exp_data = e ? 128'h0 : v.dout;
      run_vec(v, $urandom_range(0, 3));
    end

    // Reset in the middle of the DATA_IN writes drops the block.
    cfg_waits = 0;
    cfg_valid_after = 1;
    cfg_err_addr = 12'hFFF;
    wait_ready();
    in_valid = 1'b1;
    in_data  = pt0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk(!psel && !pen && !out_valid && busy && !in_ready, "midreset_state",
        {psel, pen, out_valid, busy, in_ready}, 5'b00010);
    @(negedge clk);
    rst = 1'b0;
    log_q.delete();
    wait_ready();
    chk_init();
    chk(!out_valid, "midreset_no_result", out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
